// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (two 8-byte beats) and data access (one beat).
// Data access takes 2+ cycles request-to-done; fetch takes 3+ cycles; the next grant comes one cycle after a done pulse.
// mem_req is held until mem_ready or timeout; waiting requesters see busy and hold their req level.
module mem_port_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        f_req,
   input  logic [63:0] f_addr,
   input  logic        f_flush,
   output logic        f_done,
   output logic [79:0] f_instr,
   output logic        f_err,
   output logic        f_busy,
   input  logic        m_req,
   input  logic        m_we,
   input  logic [63:0] m_addr,
   input  logic [63:0] m_wdata,
   output logic        m_done,
   output logic [63:0] m_rdata,
   output logic        m_err,
   output logic        m_busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   input  logic        mem_ready,
   input  logic        mem_err
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, F_BEAT0, F_BEAT1, M_ACC} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          cancel_q, cancel_d;
   logic          cancel_now;
   logic          timeout;

   logic          mem_req_d, mem_we_d;
   logic [63:0]   mem_addr_d, mem_wdata_d;
   logic          f_done_d, f_err_d;
   logic [79:0]   f_instr_d;
   logic          m_done_d, m_err_d;
   logic [63:0]   m_rdata_d;

   // A flush arriving in the same cycle as the beat's ready must still cancel.
   assign cancel_now = cancel_q | f_flush;
   assign timeout    = !mem_ready && (cnt_q == CNT_LAST);

   // Busy is combinational so stall logic can hold the stage in the request cycle itself.
   assign f_busy = rst_n && ((state_q == IDLE && f_req) || state_q == F_BEAT0 || state_q == F_BEAT1);
   assign m_busy = rst_n && ((state_q == IDLE && m_req) || state_q == M_ACC);

   // State, per-beat wait counter and fetch-cancel flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cancel_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cancel_q <= cancel_d;
      end
   end

   // Next-state and next-output logic for every grant/beat/completion decision.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cancel_d    = cancel_q;
      mem_req_d   = mem_req;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      f_done_d    = 1'b0;
      f_err_d     = 1'b0;
      f_instr_d   = f_instr;
      m_done_d    = 1'b0;
      m_err_d     = 1'b0;
      m_rdata_d   = m_rdata;
      case (state_q)
         IDLE: begin
            // Turnaround cycle: a requester still holding req in its done cycle is not re-granted.
            if (!f_done && !m_done) begin
               if (m_req) begin
                  state_d     = M_ACC;
                  cnt_d       = '0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = m_we;
                  mem_addr_d  = m_addr;
                  mem_wdata_d = m_wdata;
               end else if (f_req) begin
                  state_d     = F_BEAT0;
                  cnt_d       = '0;
                  cancel_d    = 1'b0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = f_addr;
                  mem_wdata_d = '0;
               end
            end
         end
         F_BEAT0, F_BEAT1: begin
            cancel_d = cancel_now;
            if (mem_ready) begin
               if (cancel_now) begin
                  state_d   = IDLE;
                  mem_req_d = 1'b0;
                  cancel_d  = 1'b0;
               end else if (state_q == F_BEAT0 && !mem_err) begin
                  // mem_req stays high; only the address moves on to the second beat.
                  state_d         = F_BEAT1;
                  cnt_d           = '0;
                  f_instr_d[63:0] = mem_rdata;
                  mem_addr_d      = mem_addr + 64'd8;
               end else begin
                  // Either a clean second beat or an error on either beat ends the fetch.
                  state_d   = IDLE;
                  mem_req_d = 1'b0;
                  f_done_d  = 1'b1;
                  f_err_d   = mem_err;
                  if (!mem_err) begin
                     f_instr_d[79:64] = mem_rdata[15:0];
                  end
               end
            end else if (timeout) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               cancel_d  = 1'b0;
               f_done_d  = !cancel_now;
               f_err_d   = !cancel_now;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         M_ACC: begin
            if (mem_ready) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               m_done_d  = 1'b1;
               m_err_d   = mem_err;
               if (!mem_we) begin
                  m_rdata_d = mem_rdata;
               end
            end else if (timeout) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               m_done_d  = 1'b1;
               m_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs, all cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         f_done    <= 1'b0;
         f_err     <= 1'b0;
         f_instr   <= '0;
         m_done    <= 1'b0;
         m_err     <= 1'b0;
         m_rdata   <= '0;
      end else begin
         mem_req   <= mem_req_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         f_done    <= f_done_d;
         f_err     <= f_err_d;
         f_instr   <= f_instr_d;
         m_done    <= m_done_d;
         m_err     <= m_err_d;
         m_rdata   <= m_rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random requesters and a random-latency memory, checked each cycle
// against a transaction-level model (port owner, beat number, cycles waited), plus literal
// expectations for fetch assembly, priority, flush, timeout, error, wrap and reset.
module tb_mem_port_arbiter;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        f_req, f_flush, f_done, f_err, f_busy;
   logic [63:0] f_addr;
   logic [79:0] f_instr;
   logic        m_req, m_we, m_done, m_err, m_busy;
   logic [63:0] m_addr, m_wdata, m_rdata;
   logic        mem_req, mem_we, mem_ready, mem_err;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;

   mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_done(f_done),
      .f_instr(f_instr), .f_err(f_err), .f_busy(f_busy),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_done(m_done), .m_rdata(m_rdata), .m_err(m_err), .m_busy(m_busy),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // memory responder configuration
   int wcnt = -1;
   int cfg_wait = 0;
   bit cfg_hang = 0;
   bit cfg_err = 0;
   bit cfg_rand = 0;

   // reference model: who owns the port, which beat, how long it has waited
   int          owner = 0;      // 0 none, 1 fetch, 2 data
   int          beat = 0;
   int          waited = 0;
   bit          cancel = 0;
   logic [63:0] fa = '0, ma = '0;
   logic        mwe = 1'b0;
   logic        e_mem_req = 0, e_mem_we = 0, e_f_done = 0, e_f_err = 0, e_m_done = 0, e_m_err = 0;
   logic [63:0] e_mem_addr = '0, e_mem_wdata = '0, e_m_rdata = '0;
   logic [79:0] e_f_instr = '0;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] mem_byte(input logic [63:0] a);
      logic [7:0] lo;
      lo = a[7:0] + 8'd1;
      return 8'(lo * 8'h11) ^ a[23:16] ^ a[63:56];
   endfunction

   function automatic logic [63:0] mem_word(input logic [63:0] a);
      logic [63:0] w;
      if (a == 64'h200) return 64'hDEAD;
      for (int i = 0; i < 8; i++) w[8*i +: 8] = mem_byte(a + 64'(i));
      return w;
   endfunction

   // an instruction is simply the ten bytes starting at its address
   function automatic logic [79:0] fetch_bytes(input logic [63:0] a);
      logic [79:0] r;
      for (int i = 0; i < 10; i++) r[8*i +: 8] = mem_byte(a + 64'(i));
      return r;
   endfunction

   function automatic logic [63:0] rand_addr();
      if ($urandom_range(0, 7) == 0) return 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      return {1'b1, 31'($urandom), $urandom};
   endfunction

   function automatic int pick_wait();
      if (cfg_hang) return 1000;
      if (cfg_wait >= 0) return cfg_wait;
      if ($urandom_range(0, 49) == 0) return 1000;
      return int'($urandom_range(0, 3));
   endfunction

   task automatic model_reset();
      owner = 0; beat = 0; waited = 0; cancel = 0;
      e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
      e_f_done = 0; e_f_err = 0; e_f_instr = '0;
      e_m_done = 0; e_m_err = 0; e_m_rdata = '0;
   endtask

   // one clock of the transaction-level model, using the inputs present at the edge
   task automatic model_step();
      logic pd;
      pd = e_f_done | e_m_done;
      e_f_done = 0; e_f_err = 0; e_m_done = 0; e_m_err = 0;
      if (owner == 0) begin
         if (!pd && m_req) begin
            owner = 2; waited = 0; ma = m_addr; mwe = m_we;
            e_mem_req = 1; e_mem_we = m_we; e_mem_addr = m_addr; e_mem_wdata = m_wdata;
         end else if (!pd && f_req) begin
            owner = 1; beat = 0; waited = 0; cancel = 0; fa = f_addr;
            e_mem_req = 1; e_mem_we = 0; e_mem_addr = f_addr;
         end
      end else if (owner == 1) begin
         cancel = cancel | f_flush;
         if (mem_ready) begin
            if (cancel) begin
               owner = 0; e_mem_req = 0;
            end else if (beat == 0 && !mem_err) begin
               beat = 1; waited = 0; e_mem_addr = fa + 64'd8;
            end else begin
               owner = 0; e_mem_req = 0; e_f_done = 1; e_f_err = mem_err;
               if (!mem_err) e_f_instr = fetch_bytes(fa);
            end
         end else begin
            waited++;
            if (waited >= TIMEOUT) begin
               owner = 0; e_mem_req = 0;
               if (!cancel) begin e_f_done = 1; e_f_err = 1; end
            end
         end
      end else begin
         if (mem_ready) begin
            owner = 0; e_mem_req = 0; e_m_done = 1; e_m_err = mem_err;
            if (!mwe && !mem_err) e_m_rdata = mem_word(ma);
         end else begin
            waited++;
            if (waited >= TIMEOUT) begin
               owner = 0; e_mem_req = 0; e_m_done = 1; e_m_err = 1;
            end
         end
      end
   endtask

   task automatic check_regs();
      chk("mem_req", 80'(mem_req), 80'(e_mem_req));
      if (e_mem_req) begin
         chk("mem_addr", 80'(mem_addr), 80'(e_mem_addr));
         chk("mem_we", 80'(mem_we), 80'(e_mem_we));
         if (e_mem_we) chk("mem_wdata", 80'(mem_wdata), 80'(e_mem_wdata));
      end
      chk("f_done", 80'(f_done), 80'(e_f_done));
      chk("m_done", 80'(m_done), 80'(e_m_done));
      if (e_f_done) begin
         chk("f_err", 80'(f_err), 80'(e_f_err));
         if (!e_f_err) chk("f_instr", f_instr, e_f_instr);
      end
      if (e_m_done) begin
         chk("m_err", 80'(m_err), 80'(e_m_err));
         if (!e_m_err && !mwe) chk("m_rdata", 80'(m_rdata), 80'(e_m_rdata));
      end
   endtask

   task automatic check_busy();
      chk("f_busy", 80'(f_busy), 80'(rst_n && ((owner == 0 && f_req) || owner == 1)));
      chk("m_busy", 80'(m_busy), 80'(rst_n && ((owner == 0 && m_req) || owner == 2)));
   endtask

   task automatic respond();
      if (!mem_req) begin
         mem_ready = 0; mem_err = 0; wcnt = -1;
      end else begin
         if (wcnt < 0) wcnt = pick_wait();
         if (wcnt == 0) begin
            mem_ready = 1;
            mem_rdata = mem_word(mem_addr);
            mem_err   = cfg_err || (cfg_rand && ($urandom_range(0, 19) == 0));
            wcnt = -1;
         end else begin
            mem_ready = 0; mem_err = 0; mem_rdata = {$urandom, $urandom};
            wcnt--;
         end
      end
   endtask

   // inputs are set by the caller before this is called; returns just after the falling edge
   task automatic tick();
      #1 check_busy();
      @(posedge clk);
      if (!rst_n) model_reset(); else model_step();
      @(negedge clk);
      check_regs();
      respond();
   endtask

   task automatic idle(input int n);
      f_req = 0; m_req = 0; f_flush = 0;
      repeat (n) tick();
   endtask

   task automatic check_all_zero(input string p);
      chk({p, "mem_req"}, 80'(mem_req), 80'(0));
      chk({p, "mem_we"}, 80'(mem_we), 80'(0));
      chk({p, "mem_addr"}, 80'(mem_addr), 80'(0));
      chk({p, "mem_wdata"}, 80'(mem_wdata), 80'(0));
      chk({p, "f_done"}, 80'(f_done), 80'(0));
      chk({p, "f_instr"}, f_instr, 80'(0));
      chk({p, "f_err"}, 80'(f_err), 80'(0));
      chk({p, "f_busy"}, 80'(f_busy), 80'(0));
      chk({p, "m_done"}, 80'(m_done), 80'(0));
      chk({p, "m_rdata"}, 80'(m_rdata), 80'(0));
      chk({p, "m_err"}, 80'(m_err), 80'(0));
      chk({p, "m_busy"}, 80'(m_busy), 80'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      int cnt, md1, md2, fb0, fd;
      bit seen, err, bad;
      rst_n = 0; f_req = 1; m_req = 1; f_flush = 0; f_addr = 64'h40; m_we = 0;
      m_addr = '0; m_wdata = '0; mem_rdata = '0; mem_ready = 0; mem_err = 0;
      model_reset();

      // reset state, with both requests high to show busy is held low
      repeat (3) tick();
      check_all_zero("A_rst_");
      f_req = 0; m_req = 0; rst_n = 1;
      idle(2);

      // fetch assembly at 0x100, zero wait
      cfg_wait = 0; f_addr = 64'h100; f_req = 1;
      tick();
      chk("B_beat0_req", 80'(mem_req), 80'(1));
      chk("B_beat0_addr", 80'(mem_addr), 80'(64'h100));
      tick();
      chk("B_beat1_req", 80'(mem_req), 80'(1));
      chk("B_beat1_addr", 80'(mem_addr), 80'(64'h108));
      chk("B_no_early_done", 80'(f_done), 80'(0));
      tick();
      chk("B_done", 80'(f_done), 80'(1));
      chk("B_instr", f_instr, 80'hAA99_8877_6655_4433_2211);
      chk("B_err", 80'(f_err), 80'(0));
      chk("B_req_drop", 80'(mem_req), 80'(0));
      idle(2);

      // priority: data read wins, then fetch; data raised during fetch waits for it
      cfg_wait = 1; f_addr = 64'h300; f_req = 1; m_we = 0; m_addr = 64'h200; m_req = 1;
      md1 = -1; md2 = -1; fb0 = -1; fd = -1;
      for (int t = 1; t <= 40 && md2 < 0; t++) begin
         tick();
         if (m_done) begin
            if (md1 < 0) begin
               md1 = t;
               chk("C_rdata", 80'(m_rdata), 80'(64'hDEAD));
            end else md2 = t;
            m_req = 0;
         end
         if (mem_req && mem_addr == 64'h300 && fb0 < 0) begin
            fb0 = t; m_req = 1; m_we = 1; m_addr = 64'h400; m_wdata = 64'h1234;
         end
         if (f_done) begin fd = t; f_req = 0; end
      end
      chk("C_first_mdone", 80'(md1), 80'(3));
      chk("C_fetch_start", 80'(fb0), 80'(md1 + 2));
      chk("C_fetch_done_seen", 80'(fd > fb0), 80'(1));
      chk("C_data_waits", 80'(md2 > fd), 80'(1));
      idle(2);

      // flush during beat 0 with ready delayed 3 cycles
      cfg_wait = 3; f_addr = 64'h500; f_req = 1; cnt = 0; seen = 0; bad = 0;
      tick();
      if (mem_req) cnt++;
      f_flush = 1; f_req = 0;
      tick();
      if (mem_req) cnt++;
      f_flush = 0;
      for (int t = 0; t < 10; t++) begin
         tick();
         if (mem_req) cnt++;
         if (f_done) seen = 1;
         if (mem_req && mem_addr == 64'h508) bad = 1;
      end
      chk("D_beat0_cycles", 80'(cnt), 80'(4));
      chk("D_no_done", 80'(seen), 80'(0));
      chk("D_no_beat1", 80'(bad), 80'(0));
      chk("D_busy_low", 80'(f_busy), 80'(0));
      idle(1);

      // data write timeout
      cfg_hang = 1; m_we = 1; m_addr = 64'h600; m_wdata = 64'h0123_4567_89AB_CDEF; m_req = 1;
      cnt = 0; seen = 0; err = 0;
      for (int t = 0; t < 40 && !seen; t++) begin
         tick();
         if (mem_req) cnt++;
         if (m_done) begin seen = 1; err = m_err; m_req = 0; end
      end
      chk("E_req_cycles", 80'(cnt), 80'(16));
      chk("E_done", 80'(seen), 80'(1));
      chk("E_err", 80'(err), 80'(1));
      cfg_hang = 0;
      idle(2);

      // fetch error on beat 0
      cfg_wait = 0; cfg_err = 1; f_addr = 64'h700; f_req = 1; cnt = 0; seen = 0; err = 0;
      for (int t = 0; t < 10 && !seen; t++) begin
         tick();
         if (mem_req) cnt++;
         if (f_done) begin seen = 1; err = f_err; f_req = 0; end
      end
      chk("F_beats", 80'(cnt), 80'(1));
      chk("F_done", 80'(seen), 80'(1));
      chk("F_err", 80'(err), 80'(1));
      cfg_err = 0;
      idle(2);

      // beat 1 address wraps
      f_addr = 64'hFFFF_FFFF_FFFF_FFFC; f_req = 1;
      tick();
      chk("G_beat0_addr", 80'(mem_addr), 80'(64'hFFFF_FFFF_FFFF_FFFC));
      tick();
      chk("G_beat1_addr", 80'(mem_addr), 80'(64'h4));
      tick();
      chk("G_done", 80'(f_done), 80'(1));
      idle(2);

      // asynchronous reset in the middle of a data access
      cfg_hang = 1; m_we = 0; m_addr = 64'h800; m_req = 1;
      tick();
      tick();
      chk("H_in_access", 80'(mem_req), 80'(1));
      #2 rst_n = 0;
      #1 check_all_zero("H_rst_");
      model_reset(); wcnt = -1; mem_ready = 0; mem_err = 0;
      tick();
      rst_n = 1; cfg_hang = 0; cfg_wait = 0;
      tick();
      chk("H_req_after_release", 80'(mem_req), 80'(1));
      seen = 0;
      for (int t = 0; t < 10 && !seen; t++) begin
         tick();
         if (m_done) begin seen = 1; m_req = 0; end
      end
      chk("H_done_after_release", 80'(seen), 80'(1));
      idle(2);

      // random traffic against the model
      cfg_rand = 1; cfg_wait = -1;
      for (int t = 0; t < 1500; t++) begin
         tick();
         f_flush = 0;
         if (f_req && f_done) f_req = 0;
         else if (f_req && $urandom_range(0, 24) == 0) begin f_flush = 1; f_req = 0; end
         else if (!f_req && !f_done && $urandom_range(0, 2) == 0) begin f_req = 1; f_addr = rand_addr(); end
         if (m_req && m_done) m_req = 0;
         else if (!m_req && !m_done && $urandom_range(0, 2) == 0) begin
            m_req = 1; m_we = 1'($urandom_range(0, 1)); m_addr = rand_addr(); m_wdata = {$urandom, $urandom};
         end
      end
      cfg_rand = 0;
      idle(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
